// File: rtl/shared_reg_arbiter_pkg.sv
// shared_reg_arbiter_pkg
//   Common definitions for the shared holding-register arbiter:
//   FSM state encoding, a constant-evaluable ceil(log2) for sizing the
//   hold counter, and the legality check applied to the block parameters.
package shared_reg_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // ceil(log2(v)), never less than 1 so a counter always has a bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // HOLD must leave at least one frozen cycle after the load, the owner
  // ID must be able to name every requester, and R stays in 2..16.
  function automatic bit params_ok(input int hold, input int r, input int idw);
    return (hold >= 2) && (r >= 2) && (r <= 16) && ((1 << idw) >= r);
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick
//   Purely combinational round-robin picker. Returns the first set request
//   at or above ptr, wrapping to the lowest set request when nothing at or
//   above ptr is requesting.
// Ports:
//   req    in  R    request vector
//   ptr    in  IDW  round-robin start position (always < R)
//   any    out 1    at least one request is set
//   winner out IDW  index of the chosen requester
//   onehot out R    one-hot form of winner (all zero when any is low)
module rr_pick #(
  parameter int R   = 4,
  parameter int IDW = 2
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] winner,
  output logic [R-1:0]   onehot
);

  logic           hi_any;
  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] lo_idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and infers a latch.
    hi_any = 1'b0;
    hi_idx = '0;
    any    = 1'b0;
    lo_idx = '0;
    // Scanning downward lets the lowest matching index overwrite the rest:
    // hi_* finds the first request at/above ptr, lo_* the first overall,
    // which is exactly where the modulo-R scan lands after wrapping.
    for (int i = R - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) begin
        hi_any = 1'b1;
        hi_idx = IDW'(i);
      end
      if (req[i]) begin
        any    = 1'b1;
        lo_idx = IDW'(i);
      end
    end
    winner = hi_any ? hi_idx : lo_idx;
    onehot = '0;
    for (int i = 0; i < R; i++) begin
      onehot[i] = any && (winner == IDW'(i));
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Shares one N-bit holding register between R requesters. A round-robin
//   winner's word is loaded and frozen for HOLD cycles, tagged with its
//   owner and VALID, then the register is re-arbitrated (back to back if
//   anyone is requesting) or the block returns to IDLE keeping Q/OWNER.
// Ports:
//   CLK   in  1    clock, rising edge
//   RST   in  1    synchronous active-high reset
//   REQ   in  R    per-requester request
//   D     in  R*N  flattened data, requester i on D[i*N +: N]
//   GNT   out R    one-cycle one-hot pulse after the capture edge
//   Q     out N    shared register
//   OWNER out IDW  requester whose word is in Q
//   VALID out 1    Q holds a live granted word
//   BUSY  out 1    in HOLD state
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N    = 8,
  parameter int R    = 4,
  parameter int IDW  = 2,
  parameter int HOLD = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [R-1:0]   REQ,
  input  logic [R*N-1:0] D,
  output logic [R-1:0]   GNT,
  output logic [N-1:0]   Q,
  output logic [IDW-1:0] OWNER,
  output logic           VALID,
  output logic           BUSY
);

  localparam int CW = clog2(HOLD);

  if (!params_ok(HOLD, R, IDW)) begin : g_bad_params
    $error("shared_reg_arbiter: need HOLD>=2, 2<=R<=16 and 2**IDW>=R");
  end

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] ptr;

  logic           pick_any;
  logic [IDW-1:0] pick_winner;
  logic [R-1:0]   pick_onehot;
  logic           arb_open;
  logic [N-1:0]   win_data;

  rr_pick #(
    .R   (R),
    .IDW (IDW)
  ) u_pick (
    .req    (REQ),
    .ptr    (ptr),
    .any    (pick_any),
    .winner (pick_winner),
    .onehot (pick_onehot)
  );

  // Arbitration is open in IDLE and on the final hold cycle, which gives
  // bubble-free back-to-back loads.
  assign arb_open = (state == ST_IDLE) || (cnt == '0);

  always_comb begin
    win_data = '0;
    for (int i = 0; i < R; i++) begin
      if (pick_onehot[i]) win_data = D[i*N +: N];
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ptr   <= '0;
      Q     <= '0;
      OWNER <= '0;
      GNT   <= '0;
      VALID <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      GNT <= '0;
      if (arb_open && pick_any) begin
        Q     <= win_data;
        OWNER <= pick_winner;
        GNT   <= pick_onehot;
        VALID <= 1'b1;
        BUSY  <= 1'b1;
        cnt   <= CW'(HOLD - 1);
        state <= ST_HOLD;
        ptr   <= (pick_winner == IDW'(R - 1)) ? '0 : pick_winner + IDW'(1);
      end else if (state == ST_HOLD) begin
        if (cnt != '0) begin
          cnt <= cnt - CW'(1);
        end else begin
          state <= ST_IDLE;
          VALID <= 1'b0;
          BUSY  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter
//   Directed bench for shared_reg_arbiter (N=8, R=4, IDW=2, HOLD=4).
//   Inputs change and outputs are sampled 1 time unit after each rising
//   edge, so the edge after a tick sees the newly driven inputs.
module tb_shared_reg_arbiter;

  localparam int N    = 8;
  localparam int R    = 4;
  localparam int IDW  = 2;
  localparam int HOLD = 4;

  logic           CLK;
  logic           RST;
  logic [R-1:0]   REQ;
  logic [R*N-1:0] D;
  logic [R-1:0]   GNT;
  logic [N-1:0]   Q;
  logic [IDW-1:0] OWNER;
  logic           VALID;
  logic           BUSY;

  int errors = 0;
  int checks = 0;

  shared_reg_arbiter #(
    .N    (N),
    .R    (R),
    .IDW  (IDW),
    .HOLD (HOLD)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (REQ),
    .D     (D),
    .GNT   (GNT),
    .Q     (Q),
    .OWNER (OWNER),
    .VALID (VALID),
    .BUSY  (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Bounded wait for the hold to end; a timeout is a failed comparison.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (VALID !== 1'b0 && n < 16) begin
      tick();
      n++;
    end
    checks++;
    if (VALID !== 1'b0) begin
      errors++;
      $display("FAIL %s: VALID still %b after %0d cycles, required 0", name, VALID, n);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    REQ = 4'b1111;
    for (int i = 0; i < R; i++) D[i*N +: N] = 8'h50 + 8'(i);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({GNT, VALID, Q, OWNER, BUSY} !== '0) begin
        errors++;
        $display("FAIL reset_c%0d: GNT=%b VALID=%b Q=%h OWNER=%0d BUSY=%b, required all 0",
                 c, GNT, VALID, Q, OWNER, BUSY);
      end
    end
    RST = 1'b0;
    tick();
    checks++;
    if (GNT !== 4'b0001 || OWNER !== 2'd0 || Q !== 8'h50 || VALID !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: GNT=%b OWNER=%0d Q=%h VALID=%b, required 0001 0 50 1",
               GNT, OWNER, Q, VALID);
    end
    REQ = '0;
    wait_idle("reset_idle");
  endtask

  // Pointer is 1 on entry.
  task automatic test_single();
    REQ = 4'b0100;
    D[2*N +: N] = 8'hA5;
    tick();
    REQ = '0;
    checks++;
    if (GNT !== 4'b0100 || Q !== 8'hA5 || OWNER !== 2'd2 || VALID !== 1'b1 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: GNT=%b Q=%h OWNER=%0d VALID=%b BUSY=%b, required 0100 a5 2 1 1",
               GNT, Q, OWNER, VALID, BUSY);
    end
    for (int c = 1; c < HOLD; c++) begin
      tick();
      checks++;
      if (VALID !== 1'b1 || GNT !== 4'b0000) begin
        errors++;
        $display("FAIL single_hold_c%0d: VALID=%b GNT=%b, required 1 0000", c, VALID, GNT);
      end
    end
    tick();
    checks++;
    if (VALID !== 1'b0 || BUSY !== 1'b0 || Q !== 8'hA5 || OWNER !== 2'd2) begin
      errors++;
      $display("FAIL single_after: VALID=%b BUSY=%b Q=%h OWNER=%0d, required 0 0 a5 2",
               VALID, BUSY, Q, OWNER);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_own [5];
    exp_own = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    RST = 1'b1;
    tick();
    RST = 1'b0;
    REQ = 4'b1111;
    for (int i = 0; i < R; i++) D[i*N +: N] = 8'h10 + 8'(i);
    for (int g = 0; g < 5; g++) begin
      tick();
      if (g == 4) REQ = '0;
      checks++;
      if (OWNER !== exp_own[g] || GNT !== (4'b0001 << exp_own[g]) ||
          Q !== (8'h10 + 8'(exp_own[g])) || VALID !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant%0d: OWNER=%0d GNT=%b Q=%h VALID=%b, required owner %0d",
                 g, OWNER, GNT, Q, VALID, exp_own[g]);
      end
      if (g < 4) begin
        for (int c = 1; c < HOLD; c++) begin
          tick();
          checks++;
          if (VALID !== 1'b1 || GNT !== 4'b0000 || OWNER !== exp_own[g]) begin
            errors++;
            $display("FAIL rr_hold%0d_c%0d: VALID=%b GNT=%b OWNER=%0d, required 1 0000 %0d",
                     g, c, VALID, GNT, OWNER, exp_own[g]);
          end
        end
      end
    end
    wait_idle("rr_idle");
  endtask

  // Pointer is 1 on entry.
  task automatic test_wrap_skip();
    REQ = 4'b0100;
    D[2*N +: N] = 8'h22;
    tick();
    REQ = '0;
    checks++;
    if (OWNER !== 2'd2) begin
      errors++;
      $display("FAIL wrap_setup: OWNER=%0d, required 2", OWNER);
    end
    wait_idle("wrap_setup_idle");
    // Pointer now 3: scan 3 -> 0.
    REQ = 4'b0011;
    D[0*N +: N] = 8'h30;
    D[1*N +: N] = 8'h31;
    tick();
    REQ = 4'b0010;
    checks++;
    if (GNT !== 4'b0001 || OWNER !== 2'd0 || Q !== 8'h30) begin
      errors++;
      $display("FAIL wrap_to0: GNT=%b OWNER=%0d Q=%h, required 0001 0 30", GNT, OWNER, Q);
    end
    for (int c = 1; c < HOLD; c++) tick();
    tick();
    REQ = '0;
    checks++;
    if (GNT !== 4'b0010 || OWNER !== 2'd1 || Q !== 8'h31 || VALID !== 1'b1) begin
      errors++;
      $display("FAIL wrap_then1: GNT=%b OWNER=%0d Q=%h VALID=%b, required 0010 1 31 1",
               GNT, OWNER, Q, VALID);
    end
    wait_idle("wrap_idle1");
    // Pointer now 2: REQ 3 and 0 -> 3 first, then pointer wraps to 0.
    REQ = 4'b1001;
    D[3*N +: N] = 8'h43;
    D[0*N +: N] = 8'h40;
    tick();
    REQ = 4'b0001;
    checks++;
    if (GNT !== 4'b1000 || OWNER !== 2'd3 || Q !== 8'h43) begin
      errors++;
      $display("FAIL skip_to3: GNT=%b OWNER=%0d Q=%h, required 1000 3 43", GNT, OWNER, Q);
    end
    for (int c = 1; c < HOLD; c++) tick();
    tick();
    REQ = '0;
    checks++;
    if (GNT !== 4'b0001 || OWNER !== 2'd0 || Q !== 8'h40) begin
      errors++;
      $display("FAIL skip_then0: GNT=%b OWNER=%0d Q=%h, required 0001 0 40", GNT, OWNER, Q);
    end
    wait_idle("wrap_idle2");
  endtask

  // Pointer is 1 on entry.
  task automatic test_mid_hold_reset();
    REQ = 4'b0010;
    D[1*N +: N] = 8'h3C;
    tick();
    REQ = '0;
    D[1*N +: N] = 8'hFF;
    checks++;
    if (GNT !== 4'b0010 || OWNER !== 2'd1 || Q !== 8'h3C) begin
      errors++;
      $display("FAIL frz_grant: GNT=%b OWNER=%0d Q=%h, required 0010 1 3c", GNT, OWNER, Q);
    end
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++;
      if (Q !== 8'h3C || VALID !== 1'b1) begin
        errors++;
        $display("FAIL frz_hold_c%0d: Q=%h VALID=%b, required 3c 1", c, Q, VALID);
      end
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if ({GNT, VALID, Q, OWNER, BUSY} !== '0) begin
      errors++;
      $display("FAIL midrst_out: GNT=%b VALID=%b Q=%h OWNER=%0d BUSY=%b, required all 0",
               GNT, VALID, Q, OWNER, BUSY);
    end
    // Pointer back at 0: all requesting must pick requester 0.
    REQ = 4'b1111;
    tick();
    REQ = '0;
    checks++;
    if (OWNER !== 2'd0 || GNT !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_ptr: OWNER=%0d GNT=%b, required 0 0001", OWNER, GNT);
    end
    wait_idle("midrst_idle");
  endtask

  // Pointer is 1 on entry.
  task automatic test_late_req();
    REQ = 4'b0001;
    D[0*N +: N] = 8'h66;
    D[3*N +: N] = 8'h77;
    tick();
    REQ = '0;
    checks++;
    if (GNT !== 4'b0001 || OWNER !== 2'd0) begin
      errors++;
      $display("FAIL late_first: GNT=%b OWNER=%0d, required 0001 0", GNT, OWNER);
    end
    tick();
    REQ = 4'b1000;
    for (int c = 2; c < HOLD; c++) begin
      tick();
      checks++;
      if (GNT !== 4'b0000 || OWNER !== 2'd0 || Q !== 8'h66 || VALID !== 1'b1) begin
        errors++;
        $display("FAIL late_early_c%0d: GNT=%b OWNER=%0d Q=%h VALID=%b, required 0000 0 66 1",
                 c, GNT, OWNER, Q, VALID);
      end
    end
    tick();
    REQ = '0;
    checks++;
    if (GNT !== 4'b1000 || OWNER !== 2'd3 || Q !== 8'h77 || VALID !== 1'b1) begin
      errors++;
      $display("FAIL late_grant: GNT=%b OWNER=%0d Q=%h VALID=%b, required 1000 3 77 1",
               GNT, OWNER, Q, VALID);
    end
    tick();
    checks++;
    if (GNT !== 4'b0000 || VALID !== 1'b1) begin
      errors++;
      $display("FAIL late_pulse: GNT=%b VALID=%b, required 0000 1", GNT, VALID);
    end
    wait_idle("late_idle");
  endtask

  initial begin
    RST = 1'b1;
    REQ = '0;
    D   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_mid_hold_reset();
    test_late_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
